// File: rtl/phy_strap_pkg.sv
// phy_strap_pkg: shared state encoding and strap field widths for the PHY strap sequencer
package phy_strap_pkg;
  localparam int MODE_W = 4;
  localparam int ADDR_W = 5;
  typedef enum logic [2:0] {S_ASSERT, S_HOLD, S_SETTLE, S_NEXT, S_DONE} state_t;
endpackage

// File: rtl/phy_strap_timer.sv
// phy_strap_timer: loadable down-counter, tc high while the count sits at zero
module phy_strap_timer
  import phy_strap_pkg::*;
#(
  parameter int W = 8,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk_50,
  input  logic         reset_n,
  input  logic         ld,
  input  logic [W-1:0] val,
  output logic         tc
);
  logic [W-1:0] cnt;
  // load wins over counting; the count parks at zero until reloaded
  always_ff @(posedge clk_50 or negedge reset_n)
    if (!reset_n) cnt <= INIT;
    else if (ld) cnt <= val;
    else if (cnt != '0) cnt <= cnt - W'(1);
  assign tc = (cnt == '0);
endmodule

// File: rtl/phy_strap_seq.sv
// phy_strap_seq: per-PHY reset/strap/settle power-up sequencer.
// Define PHY_STRAP_PARALLEL_EN to sequence all PHYs at once instead of one by one.
module phy_strap_seq
  import phy_strap_pkg::*;
#(
  parameter int NUM_PHY       = 2,
  parameter int RST_CYCLES    = 500000,
  parameter int HOLD_CYCLES   = 50,
  parameter int SETTLE_CYCLES = 250000
) (
  input  logic                        clk_50,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [MODE_W*NUM_PHY-1:0]   strap_mode_in,
  input  logic [ADDR_W*NUM_PHY-1:0]   strap_addr_in,
  input  logic [NUM_PHY-1:0]          strap_dv_in,
  output logic [NUM_PHY-1:0]          phy_hw_rst,
  output logic [NUM_PHY-1:0]          strap_oe,
  output logic [MODE_W*NUM_PHY-1:0]   strap_mode_out,
  output logic [ADDR_W*NUM_PHY-1:0]   strap_addr_out,
  output logic [NUM_PHY-1:0]          strap_dv_out,
  output logic [NUM_PHY-1:0]          phy_ready,
  output logic                        busy
);
  localparam int MAXC = (RST_CYCLES > HOLD_CYCLES)
                      ? ((RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES)
                      : ((HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES);
  localparam int CW = $clog2(MAXC + 1);
  localparam int IW = (NUM_PHY > 1) ? $clog2(NUM_PHY) : 1;

  state_t            state;
  logic [IW-1:0]     idx;
  logic              lat, tc, ld, last;
  logic [CW-1:0]     val;
  logic [NUM_PHY-1:0] sel, nsel, lsel;

  // which PHYs the current phase acts on, and which one comes next
  always_comb begin
`ifdef PHY_STRAP_PARALLEL_EN
    sel  = '1;
    nsel = '0;
    last = 1'b1;
`else
    sel  = NUM_PHY'(1) << idx;
    nsel = sel << 1;
    last = (idx == IW'(NUM_PHY - 1));
`endif
    lsel = (state == S_ASSERT && lat) ? sel : (state == S_NEXT && !last) ? nsel : '0;
  end

  // phase durations are loaded as N-1 so each phase spans exactly N edges
  always_comb begin
    ld  = ((state == S_ASSERT || state == S_HOLD) && tc) ||
          (state == S_NEXT && !last) || (state == S_DONE && start);
    val = (state == S_ASSERT) ? CW'(HOLD_CYCLES - 1)
        : (state == S_HOLD)   ? CW'(SETTLE_CYCLES - 1)
        :                       CW'(RST_CYCLES - 1);
  end

  phy_strap_timer #(.W(CW), .INIT(CW'(RST_CYCLES - 1))) u_timer (
    .clk_50  (clk_50),
    .reset_n (reset_n),
    .ld      (ld),
    .val     (val),
    .tc      (tc)
  );

  // sequencer: latch straps on ASSERT entry, release reset, drop straps, settle, mark ready
  always_ff @(posedge clk_50 or negedge reset_n)
    if (!reset_n) begin
      state          <= S_ASSERT;
      idx            <= '0;
      lat            <= 1'b1;
      phy_hw_rst     <= '0;
      strap_oe       <= '0;
      strap_mode_out <= '0;
      strap_addr_out <= '0;
      strap_dv_out   <= '0;
      phy_ready      <= '0;
      busy           <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_PHY; i++)
        if (lsel[i]) begin
          strap_mode_out[i*MODE_W +: MODE_W] <= strap_mode_in[i*MODE_W +: MODE_W];
          strap_addr_out[i*ADDR_W +: ADDR_W] <= strap_addr_in[i*ADDR_W +: ADDR_W];
          strap_dv_out[i]                    <= strap_dv_in[i];
          strap_oe[i]                        <= 1'b1;
        end
      case (state)
        S_ASSERT: begin
          lat <= 1'b0;
          if (tc) begin
            phy_hw_rst <= phy_hw_rst | sel;
            state      <= S_HOLD;
          end
        end
        S_HOLD: if (tc) begin
          strap_oe <= strap_oe & ~sel;
          state    <= S_SETTLE;
        end
        S_SETTLE: if (tc) state <= S_NEXT;
        S_NEXT: begin
          phy_ready <= phy_ready | sel;
          if (last) begin
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            idx   <= idx + IW'(1);
            state <= S_ASSERT;
          end
        end
        S_DONE: if (start) begin
          phy_hw_rst <= '0;
          phy_ready  <= '0;
          idx        <= '0;
          lat        <= 1'b1;
          busy       <= 1'b1;
          state      <= S_ASSERT;
        end
        default: state <= S_ASSERT;
      endcase
    end
endmodule

// File: tb/tb_phy_strap_seq.sv
// tb_phy_strap_seq: directed checks of strap sequencing, start handling and async reset
module tb_phy_strap_seq;
  logic        clk_50, reset_n, start;
  logic [7:0]  strap_mode_in, strap_mode_out;
  logic [9:0]  strap_addr_in, strap_addr_out;
  logic [1:0]  strap_dv_in, strap_dv_out, phy_hw_rst, strap_oe, phy_ready;
  logic        busy;
  int          ncmp = 0, nerr = 0, e = 0;

  phy_strap_seq #(.NUM_PHY(2), .RST_CYCLES(8), .HOLD_CYCLES(3), .SETTLE_CYCLES(5)) dut (
    .clk_50         (clk_50),
    .reset_n        (reset_n),
    .start          (start),
    .strap_mode_in  (strap_mode_in),
    .strap_addr_in  (strap_addr_in),
    .strap_dv_in    (strap_dv_in),
    .phy_hw_rst     (phy_hw_rst),
    .strap_oe       (strap_oe),
    .strap_mode_out (strap_mode_out),
    .strap_addr_out (strap_addr_out),
    .strap_dv_out   (strap_dv_out),
    .phy_ready      (phy_ready),
    .busy           (busy)
  );

  initial clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic to(input int n);
    while (e < n) begin
      @(posedge clk_50);
      e++;
    end
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hw"}, 32'(phy_hw_rst), 0);
    chk({tag, "_oe"}, 32'(strap_oe), 0);
    chk({tag, "_mode"}, 32'(strap_mode_out), 0);
    chk({tag, "_addr"}, 32'(strap_addr_out), 0);
    chk({tag, "_rdy"}, 32'(phy_ready), 0);
    chk({tag, "_busy"}, 32'(busy), 1);
  endtask

  initial begin
    reset_n       = 1'b0;
    start         = 1'b0;
    strap_mode_in = 8'h3A;
    strap_addr_in = {5'h0C, 5'h11};
    strap_dv_in   = 2'b10;
    #22;
    chk_reset_vals("por");
    @(negedge clk_50);
    reset_n = 1'b1;
    e = 0;
    to(1);
    chk("e1_oe", 32'(strap_oe), 32'h1);
    chk("e1_mode", 32'(strap_mode_out), 32'h0A);
    chk("e1_hw", 32'(phy_hw_rst), 0);
    to(4);
    strap_mode_in = 8'h35;
    to(7);
    chk("e7_hw", 32'(phy_hw_rst), 0);
    to(8);
    chk("e8_hw", 32'(phy_hw_rst), 32'h1);
    to(10);
    chk("e10_oe", 32'(strap_oe), 32'h1);
    to(11);
    chk("e11_oe", 32'(strap_oe), 0);
    chk("e11_mode_kept", 32'(strap_mode_out), 32'h0A);
    to(16);
    chk("e16_rdy", 32'(phy_ready), 0);
    to(17);
    chk("e17_rdy", 32'(phy_ready), 32'h1);
    chk("e17_oe", 32'(strap_oe), 32'h2);
    chk("e17_mode", 32'(strap_mode_out), 32'h3A);
    chk("e17_addr", 32'(strap_addr_out), 32'({5'h0C, 5'h11}));
    chk("e17_dv", 32'(strap_dv_out), 32'h2);
    chk("e17_busy", 32'(busy), 1);
    to(19);
    start = 1'b1;
    to(20);
    start = 1'b0;
    chk("e20_ignored_hw", 32'(phy_hw_rst), 32'h1);
    chk("e20_ignored_rdy", 32'(phy_ready), 32'h1);
    to(24);
    chk("e24_hw", 32'(phy_hw_rst), 32'h1);
    to(25);
    chk("e25_hw", 32'(phy_hw_rst), 32'h3);
    to(28);
    chk("e28_oe", 32'(strap_oe), 0);
    to(33);
    chk("e33_rdy", 32'(phy_ready), 32'h1);
    chk("e33_busy", 32'(busy), 1);
    to(34);
    chk("e34_rdy", 32'(phy_ready), 32'h3);
    chk("e34_busy", 32'(busy), 0);
    to(39);
    chk("e39_idle_busy", 32'(busy), 0);
    start = 1'b1;
    to(40);
    start = 1'b0;
    chk("e40_hw", 32'(phy_hw_rst), 0);
    chk("e40_rdy", 32'(phy_ready), 0);
    chk("e40_busy", 32'(busy), 1);
    to(41);
    chk("e41_oe", 32'(strap_oe), 32'h1);
    chk("e41_mode", 32'(strap_mode_out), 32'h35);
    to(48);
    chk("e48_hw", 32'(phy_hw_rst), 32'h1);
    to(56);
    chk("e56_rdy", 32'(phy_ready), 0);
    to(57);
    chk("e57_rdy", 32'(phy_ready), 32'h1);
    to(59);
    chk("e59_oe", 32'(strap_oe), 32'h2);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("async");
    repeat (2) @(posedge clk_50);
    @(negedge clk_50);
    reset_n = 1'b1;
    e = 0;
    to(1);
    chk("r1_oe", 32'(strap_oe), 32'h1);
    to(7);
    chk("r7_hw", 32'(phy_hw_rst), 0);
    to(8);
    chk("r8_hw", 32'(phy_hw_rst), 32'h1);
    to(17);
    chk("r17_rdy", 32'(phy_ready), 32'h1);
    to(34);
    chk("r34_rdy", 32'(phy_ready), 32'h3);
    chk("r34_busy", 32'(busy), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
